// File: rtl/l2_line_adapter.sv
// Purpose: turns line-wide L2 read/write requests into BEATS-beat bursts on the narrow memory bus, and back.
// Latency: request to resp_o is BEATS+1 cycles without stalls; each resp_i=0 cycle in a burst adds one cycle.
// Backpressure: resp_i=0 holds the beat counter and data; requests are accepted only in IDLE.
module l2_line_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  // Clears the byte-within-line bits so memory always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                            state;
  state_t                            next;
  logic [CW-1:0]                     cnt;
  logic [ADDR_WIDTH-1:0]             addr_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] wdat_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] rdat_q;
  logic                              last_beat;

  assign last_beat = resp_i && (cnt == LAST);

  // Every output is a register or a decode of state, never of a live input.
  assign read_o    = (state == RD_BURST);
  assign write_o   = (state == WR_BURST);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign line_o    = rdat_q;
  assign burst_o   = (state == WR_BURST) ? wdat_q[cnt] : '0;

  // State register; reset aborts any burst without a completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next-state decode; write wins over read when both are requested.
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (write_i)     next = WR_BURST;
        else if (read_i) next = RD_BURST;
      end
      RD_BURST: if (last_beat) next = DONE;
      WR_BURST: if (last_beat) next = DONE;
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
  end

  // Datapath: latch request, count beats, assemble the read line beat by beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            addr_q <= address_i & ALIGN_MASK;
            cnt    <= '0;
          end
          if (write_i) wdat_q <= line_i;
        end
        RD_BURST: begin
          if (resp_i) begin
            rdat_q[cnt] <= burst_i;
            // Hold on the final beat so the counter never wraps inside a burst.
            if (cnt != LAST) cnt <= cnt + CW'(1);
          end
        end
        WR_BURST: begin
          if (resp_i && (cnt != LAST)) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_line_adapter.sv
// Directed bench for l2_line_adapter: reads, stalled read, writes, read/write collision,
// mid-burst reset and back-to-back requests, checked with immediate assertions.
module tb_l2_line_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         read_i, write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic         resp_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int resp_pulses = 0;
  int resp_a, resp_b;

  l2_line_adapter dut (
    .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_o === 1'b1) resp_pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs/checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " read_o"}, read_o, 1'b0);
    chk({tag, " write_o"}, write_o, 1'b0);
    chk({tag, " resp_o"}, resp_o, 1'b0);
  endtask

  // Read burst; 'stall' idle resp_i cycles are inserted before the third beat.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [255:0] line, input int stall);
    int beat;
    int left;
    int n;
    beat = 0;
    left = stall;
    n = 0;
    read_i = 1'b1; address_i = addr;
    tick();
    address_i = ~addr;
    while (beat < 4 && n < 20) begin
      chk({tag, " read_o"}, read_o, 1'b1);
      chk({tag, " resp_o early"}, resp_o, 1'b0);
      chk({tag, " address_o"}, address_o, addr & 32'hFFFF_FFE0);
      if (beat == 2 && left > 0) begin
        resp_i = 1'b0; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        left--;
      end else begin
        resp_i = 1'b1; burst_i = line[beat*64 +: 64];
        beat++;
      end
      n++;
      tick();
    end
    chk({tag, " resp_o"}, resp_o, 1'b1);
    chk({tag, " read_o done"}, read_o, 1'b0);
    chk({tag, " line_o"}, line_o, line);
    resp_a = resp_b;
    resp_b = cyc;
    read_i = 1'b0; resp_i = 1'b0;
    tick();
    chk({tag, " resp_o after"}, resp_o, 1'b0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [255:0] line, input bit also_read);
    write_i = 1'b1; read_i = also_read; address_i = addr; line_i = line;
    tick();
    line_i = ~line; address_i = ~addr;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " write_o"}, write_o, 1'b1);
      chk({tag, " read_o"}, read_o, 1'b0);
      chk({tag, " resp_o early"}, resp_o, 1'b0);
      chk({tag, " burst_o"}, burst_o, line[k*64 +: 64]);
      chk({tag, " address_o"}, address_o, addr & 32'hFFFF_FFE0);
      resp_i = 1'b1;
      tick();
    end
    chk({tag, " resp_o"}, resp_o, 1'b1);
    chk({tag, " write_o done"}, write_o, 1'b0);
    resp_a = resp_b;
    resp_b = cyc;
    write_i = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    tick();
    chk({tag, " resp_o after"}, resp_o, 1'b0);
  endtask

  initial begin
    logic [255:0] rline, wline, rline2, wline2;
    rline  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    wline  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    rline2 = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
    wline2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};
    resp_a = 0; resp_b = 0;

    rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'h0; line_i = '0; burst_i = '0;
    #3;
    chk_idle("reset");
    chk("reset address_o", address_o, 32'h0);
    chk("reset burst_o", burst_o, 64'h0);
    chk("reset line_o", line_o, 256'h0);
    #9 rst_n = 1'b1;
    tick();
    chk_idle("idle");

    do_read("read", 32'h0000_1234, rline, 0);
    do_read("read stall", 32'h0000_1234, rline, 2);
    chk("stall latency", resp_b - resp_a, 8);
    do_write("write", 32'h0000_0040, wline, 1'b0);
    do_write("rw collide", 32'h0000_105F, wline2, 1'b1);

    // Mid-burst reset: two beats accepted, then asynchronous reset.
    read_i = 1'b1; address_i = 32'h0000_0080;
    tick();
    resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
    tick();
    burst_i = 64'hAAAA_0000_AAAA_0000;
    tick();
    resp_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset address_o", address_o, 32'h0);
    chk("async reset burst_o", burst_o, 64'h0);
    chk("async reset line_o", line_o, 256'h0);
    read_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("post reset");
    tick();
    chk_idle("post reset 2");
    chk("no resp on abort", resp_pulses, 4);
    do_read("read after reset", 32'h0000_00A0, rline2, 0);

    // Back-to-back: write request issued the cycle after DONE.
    do_read("b2b read", 32'h0000_2000, rline, 0);
    do_write("b2b write", 32'h0000_2020, wline, 1'b0);
    chk("b2b spacing", resp_b - resp_a, 6);
    chk("resp pulse count", resp_pulses, 7);
    chk("b2b line_o kept", line_o, rline);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_line_adapter.md
# l2_line_adapter

Converts single-cycle, line-wide physical-memory requests from the L2 cache controller into multi-beat bursts on the narrow main-memory bus, and back. Sits directly downstream of the L2 controller's `pmem_*` port. Presents a line-granular read/write/resp handshake upstream and a burst handshake downstream. Owns the beat counter, line assembly and disassembly, and address alignment.

## Interface
- `LINE_WIDTH`, default 256: cache line width in bits.
- `BURST_WIDTH`, default 64: memory beat width in bits. `BEATS = LINE_WIDTH/BURST_WIDTH` (default 4).
- `ADDR_WIDTH`, default 32: byte address width.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `read_i  in  1`: line read request from L2 (its `pmem_read`).
- `write_i  in  1`: line write request from L2 (its `pmem_write`).
- `address_i  in  ADDR_WIDTH`: line address from L2.
- `line_i  in  LINE_WIDTH`: write data from L2.
- `line_o  out  LINE_WIDTH`: assembled read line to L2.
- `resp_o  out  1`: one-cycle completion pulse to L2 (its `pmem_resp`).
- `burst_i  in  BURST_WIDTH`: read beat from memory.
- `burst_o  out  BURST_WIDTH`: write beat to memory.
- `address_o  out  ADDR_WIDTH`: aligned burst address to memory.
- `read_o  out  1`: burst read request.
- `write_o  out  1`: burst write request.
- `resp_i  in  1`: memory beat acknowledge; each cycle high transfers one beat.

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE
  - `write_i` high: latch `line_i` and the aligned address, clear the beat counter, go to WR_BURST.
  - Else `read_i` high: latch the aligned address, clear the beat counter, go to RD_BURST.
  - Both high: write wins.
- Alignment: `address_o` is the latched `address_i` with the low log2(LINE_WIDTH/8) bits forced to 0 (5 bits by default). It is constant for the whole burst.
- RD_BURST
  - `read_o` = 1.
  - Each cycle `resp_i` = 1, `burst_i` is written to `line_o[BURST_WIDTH*k +: BURST_WIDTH]`, where k is the beat counter, and k increments.
  - `resp_i` = 0 stalls; the counter and data hold.
  - When beat `BEATS-1` is accepted, go to DONE.
- WR_BURST
  - `write_o` = 1.
  - `burst_o` = latched line slice k.
  - k advances on each `resp_i` = 1; `resp_i` = 0 stalls.
  - When beat `BEATS-1` is acknowledged, go to DONE.
- DONE
  - `resp_o` = 1 for exactly one cycle, then return to IDLE.
  - `read_i` and `write_i` are ignored in DONE.
- `line_o` holds the last completed read line until the next read burst starts overwriting beats. L2 samples `line_o` only when `resp_o` = 1.
- `read_i`/`write_i` changing during a burst have no effect. Requests are taken only in IDLE.
- The beat counter is log2(BEATS) bits. It never wraps mid-burst; it is cleared on entry to each burst.

## Timing
- Reset: asynchronous assertion forces IDLE immediately. `read_o`, `write_o`, `resp_o`, the beat counter, `address_o`, `burst_o` and `line_o` are all 0.
- Reset mid-burst aborts the burst with no `resp_o`. After reset deasserts, the adapter accepts a new request from IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `resp_i`, `read_i` or `write_i` to any output.
- Read, no stalls: `read_i` high in IDLE at cycle 0 → `read_o` high in cycles 1–4 → memory asserts `resp_i` in cycles 1–4 → `resp_o` high in cycle 5 with `line_o` valid → IDLE in cycle 6.
- Write, no stalls: same cadence. `burst_o` = slice 0..3 in cycles 1..4, and `resp_o` is high in cycle 5.
- Each stall cycle (`resp_i` = 0) adds one cycle of latency.
- Minimum request-to-`resp_o` latency is `BEATS+1` cycles.
- Back-to-back: a request can be accepted in the cycle after DONE, so the minimum spacing between `resp_o` pulses is `BEATS+2` cycles.
- Upstream contract: L2 holds `read_i`/`write_i` until it sees `resp_o`, and drops them no later than the cycle after.

## Test plan
- Read: `address_i` = 0x0000_1234, `read_i` = 1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive `resp_i` → `address_o` = 0x0000_1220; `resp_o` pulses once at cycle 5; `line_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Read with stalls: same as above but `resp_i` low for 2 cycles between beats 1 and 2 → `resp_o` at cycle 7; same `line_o`; `read_o` held high through cycle 6.
- Write: `line_i` = 0xDDDD…_CCCC…_BBBB…_AAAA… (each 64-bit) at 0x0000_0040 → `burst_o` = 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD… in order; `write_o` high for 4 cycles; `resp_o` at cycle 5.
- Simultaneous `read_i` = `write_i` = 1 in IDLE → write burst only; `read_o` stays 0.
- Reset: `rst_n` low after beat 2 of a read → all outputs 0 in that same cycle with no clock edge; no `resp_o`; a following read completes normally with a fresh `line_o`.
- Back-to-back read then write, with L2 re-requesting the cycle after DONE → two `resp_o` pulses 6 cycles apart; no beat is lost or duplicated.
